assoc_cache_ctrl: RTL and testbench
===================================

# assoc_cache_ctrl

Parametrised N-way set-associative, write-through, no-write-allocate data cache controller. Sits between the MEM stage and the SRAM controller. Serves 32-bit word requests from the MEM-stage pipeline register and fetches 64-bit lines over the SRAM controller handshake. Uses tree pseudo-LRU replacement. Its `ready` output drives the pipeline memory freeze.

## Interface
Parameters:
- WAYS, 2, associativity; power of two, 1..8
- SETS, 64, sets per way; power of two
- ADDR_W, 19, significant byte-address bits; the caller has already subtracted the data-memory base

Ports:
- clock  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- mem_r_en  in  1  read request, held until ready
- mem_w_en  in  1  write request, held until ready; wins if asserted together with mem_r_en
- address  in  32  byte address; only [ADDR_W-1:2] are used
- wdata  in  32  store data
- rdata  out  32  load data, valid while ready=1 and mem_r_en=1
- ready  out  1  request complete this cycle; 1 when no request is pending
- sram_rd  out  1  line read request to the SRAM controller
- sram_wr  out  1  word write request to the SRAM controller
- sram_address  out  32  read: {address[ADDR_W-1:3],3'b0}; write: {address[ADDR_W-1:2],2'b0}
- sram_wdata  out  32  equals wdata
- sram_rdata  in  64  fetched line; word0 in [31:0]
- sram_ready  in  1  SRAM transfer complete, single-cycle pulse
- hit_count, miss_count  out  32  present only under CACHE_STATS_EN

## Operation
- Address split: [1:0] byte (ignored); [2] word in line; index = [3+IDX_W-1:3] with IDX_W=log2(SETS); tag = [ADDR_W-1:3+IDX_W].
- Per way and set the controller stores a valid bit, the tag and 64 data bits. Each set has WAYS-1 PLRU bits.
- States:
  - IDLE: evaluates the request.
    - Read hit: ready=1, rdata = selected word, PLRU updated.
    - Read miss: go to FILL, ready=0.
    - Any write: go to WRITE, ready=0.
  - FILL: sram_rd=1 until sram_ready. In the sram_ready cycle:
    - The line is written into the victim way (valid=1, tag written).
    - rdata = sram_rdata word selected by address[2], ready=1, PLRU updated.
    - Next state IDLE.
  - WRITE: sram_wr=1 until sram_ready. In the sram_ready cycle:
    - On a tag hit, the matching word in the hit way is updated and PLRU is updated.
    - On a miss, no allocation.
    - ready=1; next state IDLE.
- Victim selection: lowest-index invalid way, otherwise the PLRU victim. PLRU bits are set to point away from the accessed way.
- The hit check in WRITE and FILL uses current array contents. Requests are held stable, so the result is the same as in IDLE.
- The requester keeps address, wdata and enables stable while ready=0.
- No request in IDLE: ready=1, sram_rd=sram_wr=0, and no state changes.

## Timing
- Reset values: state IDLE; all valid bits 0; PLRU bits 0; sram_rd=0; sram_wr=0; counters 0. ready=1 while no request is pending. rdata=0 when not reading.
- Read hit: zero wait states. ready is combinational in the request cycle.
- Read miss: 1 cycle in IDLE plus L cycles in FILL, where L is the SRAM latency to sram_ready. ready pulses in the last cycle.
- Write: 1 + L cycles, always.
- sram_rd and sram_wr are decoded from state only (glitch-free w.r.t. inputs). Never both 1.
- rst mid-FILL or mid-WRITE: sram_rd and sram_wr drop immediately, all lines invalidate, and the partial operation leaves no cache update.
- sram_ready outside FILL or WRITE is ignored.
- Back-to-back requests: a new request is evaluated in the IDLE cycle after completion. Hits on consecutive cycles each complete in one cycle.

## Configuration
- CACHE_STATS_EN defined: hit_count and miss_count ports exist.
  - hit_count increments on each read hit (IDLE with ready=1).
  - miss_count increments on each FILL completion.
  - Both saturate at 2^32-1 and clear on rst.
- Writes are not counted.
- Without the macro the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Package cache_pkg:
  - state enum {IDLE, FILL, WRITE}
  - default WAYS/SETS/ADDR_W
  - width helpers for IDX_W and TAG_W
  - word-select constant
- Sub-module plru_tree (parameter WAYS):
  - Combinational.
  - Takes the current set bits and the accessed way; gives the next bits and the victim way.
  - Instantiated once, on the indexed set.

## Test plan
- After reset, read 0x100 with SRAM latency 3: sram_rd=1 with sram_address 0x100. Ready after 4 cycles, returning sram_rdata[31:0]. Then read 0x104: 0-wait hit returning sram_rdata[63:32], sram_rd stays 0.
- WAYS=2, SETS=64 (set stride 0x200): read A=0x000, B=0x200, A again (hit), then C=0x400. C evicts B. Then A hits and B misses.
- Write 0xDEADBEEF to cached 0x104: sram_wr=1 with sram_address 0x104 until sram_ready. Then read 0x104 hits with 0xDEADBEEF and no sram_rd.
- Write 0x12345678 to uncached 0x600: write-through with no allocation. A following read of 0x600 misses (sram_rd asserted).
- rst asserted two cycles into a FILL: sram_rd=0 the same cycle and state is IDLE. A previously cached 0x100 now misses.
- CACHE_STATS_EN with the scenario-2 sequence: hit_count=2, miss_count=4.

Source files
------------

// File: rtl/assoc_cache_ctrl_pkg.sv
// Shared types, default geometry and width helpers for the set-associative data cache.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE
  } state_e;

  localparam int DEF_WAYS   = 2;
  localparam int DEF_SETS   = 64;
  localparam int DEF_ADDR_W = 19;

  // Byte-address bit that picks the 32-bit word inside a 64-bit line.
  localparam int WORD_SEL_BIT = 2;

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int sets);
    return addr_w - 3 - $clog2(sets);
  endfunction

  // Way-number width; a direct-mapped cache still carries one bit.
  function automatic int way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  // Pseudo-LRU bits per set; WAYS=1 still gets a single unused bit so the width stays legal.
  function automatic int plru_w(input int ways);
    return (ways > 1) ? ways - 1 : 1;
  endfunction

endpackage

// File: rtl/assoc_cache_ctrl_if.sv
// Word request bus between the MEM-stage pipeline register and the data cache.
interface assoc_cache_ctrl_if;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (output mem_r_en, mem_w_en, address, wdata, input rdata, ready);
  modport slave  (input mem_r_en, mem_w_en, address, wdata, output rdata, ready);
endinterface

// File: rtl/assoc_cache_ctrl_plru.sv
// Tree pseudo-LRU for one set: heap-ordered nodes, a node bit of 1 steers the victim right.
module plru_tree
  import cache_pkg::*;
#(
  parameter int WAYS = DEF_WAYS
) (
  input  logic [plru_w(WAYS)-1:0] bits_i,
  input  logic [way_w(WAYS)-1:0]  access_i,
  output logic [plru_w(WAYS)-1:0] bits_o,
  output logic [way_w(WAYS)-1:0]  victim_o
);
  localparam int WW  = way_w(WAYS);
  localparam int PW  = plru_w(WAYS);
  localparam int NW  = (PW > 1) ? $clog2(PW) : 1;
  localparam int LVL = $clog2(WAYS);

  int   node;
  logic dir;

  // Walk the accessed way's path flipping nodes away from it, then walk the old bits to find the victim.
  always_comb begin
    bits_o   = bits_i;
    victim_o = '0;
    dir      = 1'b0;
    node     = 0;
    for (int l = 0; l < LVL; l++) begin
      dir                = access_i[WW'(LVL - 1 - l)];
      bits_o[NW'(node)]  = ~dir;
      node               = 2 * node + 1 + int'(dir);
    end
    node = 0;
    for (int l = 0; l < LVL; l++) begin
      dir                          = bits_i[NW'(node)];
      victim_o[WW'(LVL - 1 - l)]   = dir;
      node                         = 2 * node + 1 + int'(dir);
    end
  end

endmodule

// File: rtl/assoc_cache_ctrl.sv
// Write-through, no-write-allocate N-way data cache between the MEM stage and the SRAM controller.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module assoc_cache_ctrl
  import cache_pkg::*;
#(
  parameter int WAYS   = DEF_WAYS,
  parameter int SETS   = DEF_SETS,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                clock,
  input  logic                rst,
  assoc_cache_ctrl_if.slave   bus,
  output logic                sram_rd,
  output logic                sram_wr,
  output logic [31:0]         sram_address,
  output logic [31:0]         sram_wdata,
  input  logic [63:0]         sram_rdata,
`ifdef CACHE_STATS_EN
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count,
`endif
  input  logic                sram_ready
);
  localparam int IDX_W = idx_w(SETS);
  localparam int TAG_W = tag_w(ADDR_W, SETS);
  localparam int WW    = way_w(WAYS);
  localparam int PW    = plru_w(WAYS);

  state_e           state_q;
  logic             sram_rd_q, sram_wr_q;
  logic             valid_q [WAYS][SETS];
  logic [TAG_W-1:0] tag_q   [WAYS][SETS];
  logic [63:0]      data_q  [WAYS][SETS];
  logic [PW-1:0]    plru_q  [SETS];
  logic [PW-1:0]    plru_d;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             wordSel;
  logic             rdReq, hit, invFound;
  logic [WW-1:0]    hitWay, invWay, plruVictim, victimWay, accWay;
  logic [63:0]      hitLine;
  logic             readHit, fillDone, writeDone, plruWe;
  logic             unusedAddr;

  assign idx        = bus.address[3+IDX_W-1:3];
  assign tag        = bus.address[ADDR_W-1:3+IDX_W];
  assign wordSel    = bus.address[WORD_SEL_BIT];
  assign unusedAddr = ^{bus.address[31:ADDR_W], bus.address[1:0]};
  assign rdReq      = bus.mem_r_en & ~bus.mem_w_en;

  // Tag compare across all ways of the indexed set; lowest-numbered invalid way is remembered for refills.
  always_comb begin
    hit      = 1'b0;
    hitWay   = '0;
    invFound = 1'b0;
    invWay   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[WW'(w)][idx] && (tag_q[WW'(w)][idx] == tag)) begin
        hit    = 1'b1;
        hitWay = WW'(w);
      end
      if (!valid_q[WW'(w)][idx]) begin
        invFound = 1'b1;
        invWay   = WW'(w);
      end
    end
  end

  assign victimWay = invFound ? invWay : plruVictim;
  assign accWay    = (state_q == FILL) ? victimWay : hitWay;
  assign hitLine   = data_q[hitWay][idx];

  plru_tree #(.WAYS(WAYS)) u_plru (
    .bits_i   (plru_q[idx]),
    .access_i (accWay),
    .bits_o   (plru_d),
    .victim_o (plruVictim)
  );

  assign readHit   = (state_q == IDLE) && rdReq && hit;
  assign fillDone  = (state_q == FILL) && sram_ready;
  assign writeDone = (state_q == WRITE) && sram_ready;
  assign plruWe    = readHit | fillDone | (writeDone & hit);

  // Completion and load data: hits answer straight from the array, fills forward the incoming line.
  always_comb begin
    bus.ready = 1'b0;
    bus.rdata = '0;
    case (state_q)
      IDLE: begin
        if (!bus.mem_r_en && !bus.mem_w_en) begin
          bus.ready = 1'b1;
        end else if (readHit) begin
          bus.ready = 1'b1;
          bus.rdata = wordSel ? hitLine[63:32] : hitLine[31:0];
        end
      end
      FILL: begin
        if (sram_ready) begin
          bus.ready = 1'b1;
          bus.rdata = wordSel ? sram_rdata[63:32] : sram_rdata[31:0];
        end
      end
      WRITE: bus.ready = sram_ready;
      default: bus.ready = 1'b0;
    endcase
  end

  // Controller FSM with registered SRAM strobes; reset wipes valid and PLRU state so a cut-off fill leaves nothing behind.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sram_rd_q <= 1'b0;
      sram_wr_q <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        plru_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          valid_q[w][s] <= 1'b0;
        end
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.mem_w_en) begin
            state_q   <= WRITE;
            sram_wr_q <= 1'b1;
          end else if (bus.mem_r_en && !hit) begin
            state_q   <= FILL;
            sram_rd_q <= 1'b1;
          end
        end
        FILL: begin
          if (sram_ready) begin
            state_q                <= IDLE;
            sram_rd_q              <= 1'b0;
            valid_q[victimWay][idx] <= 1'b1;
          end
        end
        WRITE: begin
          if (sram_ready) begin
            state_q   <= IDLE;
            sram_wr_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          sram_rd_q <= 1'b0;
          sram_wr_q <= 1'b0;
        end
      endcase
      if (plruWe) begin
        plru_q[idx] <= plru_d;
      end
    end
  end

  // Tag and data storage need no reset since the valid bits gate every use of them.
  always_ff @(posedge clock) begin
    if (fillDone) begin
      tag_q[victimWay][idx]  <= tag;
      data_q[victimWay][idx] <= sram_rdata;
    end else if (writeDone && hit) begin
      if (wordSel) begin
        data_q[hitWay][idx][63:32] <= bus.wdata;
      end else begin
        data_q[hitWay][idx][31:0] <= bus.wdata;
      end
    end
  end

  assign sram_rd      = sram_rd_q;
  assign sram_wr      = sram_wr_q;
  assign sram_wdata   = bus.wdata;
  assign sram_address = (state_q == WRITE) ? 32'({bus.address[ADDR_W-1:2], 2'b00})
                                           : 32'({bus.address[ADDR_W-1:3], 3'b000});

`ifdef CACHE_STATS_EN
  logic [31:0] hit_q, miss_q;

  // Saturating read-hit and line-fill counters.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (readHit && (hit_q != 32'hFFFF_FFFF)) begin
        hit_q <= hit_q + 32'd1;
      end
      if (fillDone && (miss_q != 32'hFFFF_FFFF)) begin
        miss_q <= miss_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`endif

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Directed bench for assoc_cache_ctrl with an SRAM responder model and a read-data scoreboard.
// Build with CACHE_STATS_EN defined to also check the hit/miss counters.
module tb_assoc_cache_ctrl;

  logic        clock = 1'b0;
  logic        rst;
  logic        sram_rd, sram_wr, sram_ready;
  logic [31:0] sram_address, sram_wdata;
  logic [63:0] sram_rdata;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] expQ [$];
  logic [31:0] wmem [logic [31:0]];

  assoc_cache_ctrl_if bus ();

  assoc_cache_ctrl dut (
    .clock        (clock),
    .rst          (rst),
    .bus          (bus),
    .sram_rd      (sram_rd),
    .sram_wr      (sram_wr),
    .sram_address (sram_address),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata),
`ifdef CACHE_STATS_EN
    .hit_count    (hit_count),
    .miss_count   (miss_count),
`endif
    .sram_ready   (sram_ready)
  );

  always #5 clock = ~clock;

  // Backing memory contents: written words, otherwise a per-address pattern.
  function automatic logic [31:0] modelWord(input logic [31:0] a);
    logic [31:0] wa;
    wa = a & 32'h0007_FFFC;
    if (wmem.exists(wa)) return wmem[wa];
    return wa ^ 32'h5EED_0000;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyReset();
    @(negedge clock);
    rst = 1'b1;
    bus.mem_r_en = 1'b0;
    bus.mem_w_en = 1'b0;
    sram_ready   = 1'b0;
    #1;
    checkOutput("reset sram_rd", 32'(sram_rd), 32'd0);
    checkOutput("reset sram_wr", 32'(sram_wr), 32'd0);
    repeat (2) @(negedge clock);
    rst = 1'b0;
    #1;
    checkOutput("reset ready", 32'(bus.ready), 32'd1);
    checkOutput("reset rdata", bus.rdata, 32'd0);
`ifdef CACHE_STATS_EN
    checkOutput("reset hit_count", hit_count, 32'd0);
    checkOutput("reset miss_count", miss_count, 32'd0);
`endif
  endtask

  // One complete request with the SRAM answering after lat cycles of rd/wr strobe.
  task automatic applyStimulus(input string tag, input bit wr, input logic [31:0] addr,
                               input logic [31:0] data, input int lat, input bit expHit);
    int          busy;
    bit          done;
    int          doneCyc;
    logic [31:0] lineAddr, expAddr, expData;
    lineAddr = addr & 32'h0007_FFF8;
    expAddr  = wr ? (addr & 32'h0007_FFFC) : lineAddr;
    @(negedge clock);
    bus.address  = addr;
    bus.wdata    = data;
    bus.mem_w_en = wr;
    bus.mem_r_en = !wr;
    if (wr) wmem[addr & 32'h0007_FFFC] = data;
    else expQ.push_back(modelWord(addr));
    busy    = 0;
    done    = 1'b0;
    doneCyc = -1;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (cyc > 0) @(negedge clock);
      if (sram_rd || sram_wr) begin
        busy++;
        if (busy == 1) begin
          checkOutput({tag, " sram_rd"}, 32'(sram_rd), 32'(!wr));
          checkOutput({tag, " sram_wr"}, 32'(sram_wr), 32'(wr));
          checkOutput({tag, " sram_address"}, sram_address, expAddr);
          if (wr) checkOutput({tag, " sram_wdata"}, sram_wdata, data);
        end
        sram_rdata = {modelWord(lineAddr + 32'd4), modelWord(lineAddr)};
        if (busy == lat) sram_ready = 1'b1;
      end
      #1;
      if (bus.ready) begin
        done    = 1'b1;
        doneCyc = cyc;
        if (!wr && expQ.size() > 0) begin
          expData = expQ.pop_front();
          checkOutput({tag, " rdata"}, bus.rdata, expData);
        end
      end
    end
    checkOutput({tag, " completed"}, 32'(done), 32'd1);
    checkOutput({tag, " latency"}, 32'(doneCyc), expHit ? 32'd0 : 32'(lat));
    @(negedge clock);
    sram_ready   = 1'b0;
    bus.mem_r_en = 1'b0;
    bus.mem_w_en = 1'b0;
    #1;
    checkOutput({tag, " idle ready"}, 32'(bus.ready), 32'd1);
    checkOutput({tag, " idle strobes"}, 32'({sram_rd, sram_wr}), 32'd0);
  endtask

  initial begin
    rst          = 1'b1;
    sram_ready   = 1'b0;
    sram_rdata   = '0;
    bus.mem_r_en = 1'b0;
    bus.mem_w_en = 1'b0;
    bus.address  = '0;
    bus.wdata    = '0;
    applyReset();

    $display("[TB] basic fill, hit, write-through");
    applyStimulus("rd 0x100 miss", 1'b0, 32'h100, 32'h0, 3, 1'b0);
    applyStimulus("rd 0x104 hit", 1'b0, 32'h104, 32'h0, 3, 1'b1);
    applyStimulus("wr 0x104", 1'b1, 32'h104, 32'hDEAD_BEEF, 2, 1'b0);
    applyStimulus("rd 0x104 after wr", 1'b0, 32'h104, 32'h0, 3, 1'b1);

    $display("[TB] replacement in set 0");
    applyStimulus("rd A miss", 1'b0, 32'h000, 32'h0, 2, 1'b0);
    applyStimulus("rd B miss", 1'b0, 32'h200, 32'h0, 2, 1'b0);
    applyStimulus("rd A hit", 1'b0, 32'h000, 32'h0, 2, 1'b1);
    applyStimulus("rd C miss", 1'b0, 32'h400, 32'h0, 2, 1'b0);
    applyStimulus("rd A hit again", 1'b0, 32'h004, 32'h0, 2, 1'b1);
    applyStimulus("rd B evicted", 1'b0, 32'h200, 32'h0, 2, 1'b0);

    $display("[TB] write miss does not allocate");
    applyStimulus("wr 0x600", 1'b1, 32'h600, 32'h1234_5678, 1, 1'b0);
    applyStimulus("rd 0x600 miss", 1'b0, 32'h600, 32'h0, 2, 1'b0);

    $display("[TB] reset during fill");
    applyStimulus("rd 0x100 cached", 1'b0, 32'h100, 32'h0, 3, 1'b1);
    @(negedge clock);
    bus.address  = 32'h108;
    bus.mem_r_en = 1'b1;
    #1;
    checkOutput("mid-fill request waits", 32'(bus.ready), 32'd0);
    repeat (2) @(negedge clock);
    checkOutput("mid-fill sram_rd", 32'(sram_rd), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("reset drops sram_rd", 32'(sram_rd), 32'd0);
    bus.mem_r_en = 1'b0;
    #1;
    checkOutput("reset returns to idle", 32'(bus.ready), 32'd1);
    @(negedge clock);
    rst = 1'b0;
    applyStimulus("rd 0x100 after reset", 1'b0, 32'h100, 32'h0, 3, 1'b0);

    $display("[TB] replacement sequence from clean reset");
    applyReset();
    applyStimulus("s2 rd A", 1'b0, 32'h000, 32'h0, 1, 1'b0);
    applyStimulus("s2 rd B", 1'b0, 32'h200, 32'h0, 1, 1'b0);
    applyStimulus("s2 rd A hit", 1'b0, 32'h000, 32'h0, 1, 1'b1);
    applyStimulus("s2 rd C", 1'b0, 32'h400, 32'h0, 1, 1'b0);
    applyStimulus("s2 rd A hit", 1'b0, 32'h000, 32'h0, 1, 1'b1);
    applyStimulus("s2 rd B", 1'b0, 32'h200, 32'h0, 1, 1'b0);
`ifdef CACHE_STATS_EN
    checkOutput("hit_count", hit_count, 32'd2);
    checkOutput("miss_count", miss_count, 32'd4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
